pipe_hazard_unit: RTL

- Parametrised hazard and forwarding scoreboard for the pipelined CPU; successor to the current fixed 4-stage datapath, which has no forwarding, stalls or branch squash.
- Tracks destination tags of in-flight instructions over STAGES post-decode stages.
- Generates per-operand forwarding selects, load-use stall and taken-branch flush for the ID-stage instruction.
- Keeps saturating stall and flush performance counters.

---
 rtl/pipe_hazard_unit.sv | 127 ++++++++++++
 1 files changed

// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: scoreboard of in-flight destination tags for a pipelined
// CPU. It drives operand forwarding selects, the load-use stall and the
// taken-branch flush for the instruction in ID, and counts stall and flush cycles.
module pipe_hazard_unit #(
   parameter int ASIZE      = 5,
   parameter int STAGES     = 3,
   parameter int LOAD_READY = 2,
   parameter int CNT_W      = 16,
   localparam int FW        = $clog2(STAGES + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [ASIZE-1:0] id_rs,
   input  logic [ASIZE-1:0] id_rt,
   input  logic             id_use_rt,
   input  logic [ASIZE-1:0] id_waddr,
   input  logic             id_wen,
   input  logic             id_memread,
   input  logic             ex_branch_taken,
   output logic             stall,
   output logic             flush,
   output logic [FW-1:0]    fwd_a,
   output logic [FW-1:0]    fwd_b,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef struct packed {
      logic             valid;
      logic [ASIZE-1:0] waddr;
      logic             wen;
      logic             memread;
   } tag_t;

   // tags[j] describes the instruction currently in post-ID stage j (1 = EX).
   tag_t tags [1:STAGES];

   logic [FW-1:0] hit_a, hit_b;   // stage index of the youngest match, 0 = none
   logic          load_a, load_b; // that youngest match is a load
   logic          hazard_a, hazard_b;
   logic          advance;        // ID instruction moves into EX this clock

   // Youngest-match search per source operand: scan oldest to youngest so the
   // smallest stage index is the last one written.
   always_comb begin
      // NOTE: every variable gets a default before the loop so no path leaves
      // it unassigned; otherwise synthesis would infer a latch.
      hit_a  = '0;
      hit_b  = '0;
      load_a = 1'b0;
      load_b = 1'b0;
      for (int j = STAGES; j >= 1; j--) begin
         if (tags[j].valid && tags[j].wen && tags[j].waddr == id_rs && id_rs != '0) begin
            hit_a  = FW'(j);
            load_a = tags[j].memread;
         end
         if (tags[j].valid && tags[j].wen && tags[j].waddr == id_rt && id_rt != '0) begin
            hit_b  = FW'(j);
            load_b = tags[j].memread;
         end
      end
      // rs is a source whenever ID is valid; rt only when the opcode uses it.
      if (!id_valid) begin
         hit_a  = '0;
         load_a = 1'b0;
      end
      if (!(id_valid && id_use_rt)) begin
         hit_b  = '0;
         load_b = 1'b0;
      end
   end

   // Hazard decode: branch squash beats load-use stall; both forced low in reset.
   always_comb begin
      hazard_a = load_a && (hit_a != '0) && (hit_a < FW'(LOAD_READY));
      hazard_b = load_b && (hit_b != '0) && (hit_b < FW'(LOAD_READY));
      flush    = rst && ex_branch_taken;
      stall    = rst && id_valid && !flush && (hazard_a || hazard_b);
      advance  = id_valid && !stall && !flush;
   end

   // Tag pipeline: shift one stage per clock, bubble in when ID does not advance.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: the tag array is only STAGES entries and its valid bits gate
         // every hazard decision, so it is cleared by reset like any register.
         for (int j = 1; j <= STAGES; j++) begin
            tags[j] <= '0;
         end
      end else begin
         // NOTE: non-blocking assignments make every stage read the previous
         // stage's old value, which is what a shift register requires.
         tags[1] <= advance ? '{valid: 1'b1, waddr: id_waddr, wen: id_wen,
                                memread: id_memread} : '0;
         for (int j = 2; j <= STAGES; j++) begin
            tags[j] <= tags[j-1];
         end
      end
   end

   // Forwarding selects, registered so they are valid during the consumer's EX.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fwd_a <= '0;
         fwd_b <= '0;
      end else if (advance) begin
         fwd_a <= hit_a;
         fwd_b <= hit_b;
      end else begin
         fwd_a <= '0;
         fwd_b <= '0;
      end
   end

   // Saturating performance counters for stall and flush cycles.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
         if (flush && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
      end
   end

endmodule
